// File: rtl/nios_mem_arb_pkg.sv
// Shared widths, master indices and request bundle type for the on-chip RAM arbiter.
package nios_mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 9;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned BE_W       = ARB_DATA_W / 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] address;
    logic [BE_W-1:0]       byteenable;
    logic                  read;
    logic                  write;
    logic [ARB_DATA_W-1:0] writedata;
  } mem_req_t;

endpackage

// File: rtl/nios_mem_arb_rr2.sv
// Two-way round-robin grant with a registered last-granted index.
module nios_mem_arb_rr2 #(
  parameter logic InitGrantLast = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // On contention the master that was not served last wins.
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    last_d = last_q;
    if (|grant_o) last_d = grant_o[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= InitGrantLast;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/nios_onchip_mem_arbiter.sv
// Two-master round-robin front end for the 512x32 single-port on-chip RAM.
module nios_onchip_mem_arbiter
  import nios_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = ARB_ADDR_W,
  parameter int unsigned DATA_W          = ARB_DATA_W,
  parameter logic        INIT_GRANT_LAST = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic       req0, req1;
  logic [1:0] grant;
  logic       rd_accept;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  nios_mem_arb_rr2 #(
    .InitGrantLast (INIT_GRANT_LAST)
  ) u_rr2 (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .req_i   ({req1, req0}),
    .grant_o (grant)
  );

  assign m0_waitrequest = req0 & ~grant[M0];
  assign m1_waitrequest = req1 & ~grant[M1];

  // Idle cycles fall through to m0's fields; chipselect keeps the RAM quiet.
  always_comb begin
    mem_address    = grant[M1] ? m1_address    : m0_address;
    mem_byteenable = grant[M1] ? m1_byteenable : m0_byteenable;
    mem_writedata  = grant[M1] ? m1_writedata  : m0_writedata;
    mem_write      = (grant[M0] & m0_write) | (grant[M1] & m1_write);
    mem_chipselect = |grant;
  end

  assign mem_clken = 1'b1;

  // Read with write asserted together is handled as a write only.
  assign rd_accept = (grant[M0] & m0_read & ~m0_write) | (grant[M1] & m1_read & ~m1_write);

  always_comb begin
    rd_pend_d = rd_accept;
    rd_id_d   = rd_accept ? grant[M1] : rd_id_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= M0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  assign m0_readdatavalid = rd_pend_q & (rd_id_q == M0);
  assign m1_readdatavalid = rd_pend_q & (rd_id_q == M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// Directed bench for the on-chip RAM arbiter with a behavioural 512x32 RAM behind it.
module tb_nios_onchip_mem_arbiter;
  import nios_mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_onchip_mem_arbiter #(
    .ADDR_W          (9),
    .DATA_W          (32),
    .INIT_GRANT_LAST (1'b1)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // RAM model: registered q, updated only on reads.
  logic [31:0] ram [512];
  logic [31:0] q;
  logic        ram_init;
  assign mem_readdata = q;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 512; k++) ram[k] <= 32'h0;
      ram[5] <= 32'hDEADBEEF;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        q <= ram[mem_address];
      end
    end
  end

  typedef struct {
    mem_req_t    r0;
    mem_req_t    r1;
    logic [3:0]  exp;   // {wait0, wait1, chipselect, write}
    logic [8:0]  addr;  // checked only when chipselect is expected
    logic [1:0]  rdv;   // {valid1, valid0}
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic mem_req_t rq(logic rd, logic wr, logic [8:0] a, logic [3:0] be,
                                  logic [31:0] wd);
    mem_req_t r;
    r.address = a; r.byteenable = be; r.read = rd; r.write = wr; r.writedata = wd;
    return r;
  endfunction

  function automatic vec_t mk(mem_req_t r0, mem_req_t r1, logic [3:0] exp, logic [8:0] addr,
                              logic [1:0] rdv, logic [31:0] rdata);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.exp = exp; v.addr = addr; v.rdv = rdv; v.rdata = rdata;
    return v;
  endfunction

  task automatic drive(mem_req_t a, mem_req_t b);
    m0_address = a.address; m0_byteenable = a.byteenable; m0_read = a.read;
    m0_write = a.write; m0_writedata = a.writedata;
    m1_address = b.address; m1_byteenable = b.byteenable; m1_read = b.read;
    m1_write = b.write; m1_writedata = b.writedata;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  initial begin
    mem_req_t idle;
    idle = rq(1'b0, 1'b0, 9'h0, 4'h0, 32'h0);

    vecs.push_back(mk(rq(1, 0, 9'h005, 4'hF, 0), idle, 4'b0010, 9'h005, 2'b00, 0));
    vecs.push_back(mk(idle, rq(1, 0, 9'h005, 4'hF, 0), 4'b0010, 9'h005, 2'b01, 32'hDEADBEEF));
    vecs.push_back(mk(idle, idle, 4'b0000, 9'h000, 2'b10, 32'hDEADBEEF));
    vecs.push_back(mk(rq(0, 1, 9'h010, 4'hF, 32'h11111111),
                      rq(0, 1, 9'h011, 4'hF, 32'h22222222), 4'b0111, 9'h010, 2'b00, 0));
    vecs.push_back(mk(idle, rq(0, 1, 9'h011, 4'hF, 32'h22222222), 4'b0011, 9'h011, 2'b00, 0));
    vecs.push_back(mk(rq(1, 0, 9'h010, 4'hF, 0), idle, 4'b0010, 9'h010, 2'b00, 0));
    vecs.push_back(mk(idle, rq(1, 0, 9'h011, 4'hF, 0), 4'b0010, 9'h011, 2'b01, 32'h11111111));
    vecs.push_back(mk(idle, idle, 4'b0000, 9'h000, 2'b10, 32'h22222222));
    // Eight cycles of sustained contention: strict alternation starting with m0.
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  rv;
      logic [31:0] rd;
      rv = (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10);
      rd = (i % 2 == 1) ? 32'h11111111 : 32'h22222222;
      vecs.push_back(mk(rq(1, 0, 9'h010, 4'hF, 0), rq(1, 0, 9'h011, 4'hF, 0),
                        (i % 2 == 0) ? 4'b0110 : 4'b1010,
                        (i % 2 == 0) ? 9'h010 : 9'h011, rv, rd));
    end
    vecs.push_back(mk(idle, idle, 4'b0000, 9'h000, 2'b10, 32'h22222222));
    vecs.push_back(mk(idle, rq(0, 1, 9'h020, 4'b0101, 32'hAABBCCDD), 4'b0011, 9'h020, 2'b00, 0));
    vecs.push_back(mk(idle, rq(1, 0, 9'h020, 4'hF, 0), 4'b0010, 9'h020, 2'b00, 0));
    vecs.push_back(mk(idle, idle, 4'b0000, 9'h000, 2'b10, 32'h00BB00DD));
    vecs.push_back(mk(rq(1, 1, 9'h030, 4'hF, 32'h12345678), idle, 4'b0011, 9'h030, 2'b00, 0));
    vecs.push_back(mk(idle, idle, 4'b0000, 9'h000, 2'b00, 0));
    vecs.push_back(mk(rq(1, 0, 9'h030, 4'hF, 0), idle, 4'b0010, 9'h030, 2'b00, 0));
    vecs.push_back(mk(idle, idle, 4'b0000, 9'h000, 2'b01, 32'h12345678));

    reset_n  = 1'b0;
    ram_init = 1'b1;
    drive(idle, idle);
    @(posedge clk); #1 ram_init = 1'b0;
    @(negedge clk);
    chk("reset m0_readdatavalid", 32'(m0_readdatavalid), 0);
    chk("reset m1_readdatavalid", 32'(m1_readdatavalid), 0);
    chk("reset mem_chipselect", 32'(mem_chipselect), 0);
    chk("reset mem_clken", 32'(mem_clken), 1);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1 drive(vecs[i].r0, vecs[i].r1);
      @(negedge clk);
      chk($sformatf("vec%0d m0_waitrequest", i), 32'(m0_waitrequest), 32'(vecs[i].exp[3]));
      chk($sformatf("vec%0d m1_waitrequest", i), 32'(m1_waitrequest), 32'(vecs[i].exp[2]));
      chk($sformatf("vec%0d mem_chipselect", i), 32'(mem_chipselect), 32'(vecs[i].exp[1]));
      chk($sformatf("vec%0d mem_write", i), 32'(mem_write), 32'(vecs[i].exp[0]));
      if (vecs[i].exp[1])
        chk($sformatf("vec%0d mem_address", i), 32'(mem_address), 32'(vecs[i].addr));
      chk($sformatf("vec%0d m0_readdatavalid", i), 32'(m0_readdatavalid), 32'(vecs[i].rdv[0]));
      chk($sformatf("vec%0d m1_readdatavalid", i), 32'(m1_readdatavalid), 32'(vecs[i].rdv[1]));
      if (vecs[i].rdv[0]) chk($sformatf("vec%0d m0_readdata", i), m0_readdata, vecs[i].rdata);
      if (vecs[i].rdv[1]) chk($sformatf("vec%0d m1_readdata", i), m1_readdata, vecs[i].rdata);
    end

    // Reset while a read is returning: valid must drop at once, m0 wins first contention.
    @(posedge clk); #1 drive(rq(1, 0, 9'h005, 4'hF, 0), idle);
    @(negedge clk);
    chk("rst seq m0_waitrequest", 32'(m0_waitrequest), 0);
    @(posedge clk); #1 drive(idle, idle);
    chk("rst seq valid before reset", 32'(m0_readdatavalid), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst seq m0_readdatavalid dropped", 32'(m0_readdatavalid), 0);
    chk("rst seq m1_readdatavalid", 32'(m1_readdatavalid), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1 drive(rq(1, 0, 9'h010, 4'hF, 0), rq(1, 0, 9'h011, 4'hF, 0));
    @(negedge clk);
    chk("post-reset m0_waitrequest", 32'(m0_waitrequest), 0);
    chk("post-reset m1_waitrequest", 32'(m1_waitrequest), 1);
    chk("post-reset mem_address", 32'(mem_address), 32'h010);
    @(posedge clk); #1 drive(idle, idle);
    @(negedge clk);
    chk("post-reset m0_readdatavalid", 32'(m0_readdatavalid), 1);
    chk("post-reset m1_readdatavalid", 32'(m1_readdatavalid), 0);
    chk("post-reset m0_readdata", m0_readdata, 32'h11111111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_onchip_mem_arbiter.md
Name: nios_onchip_mem_arbiter

Overview:
Two-master round-robin arbiter in front of the 512x32 single-port on-chip RAM (byteenable, 1-cycle read latency, unregistered q).
- Lets the Nios II data master (m0) and a second Avalon-MM master (m1, e.g. DMA/peripheral engine) share the one RAM port.
- Issues at most one access per cycle.
- Returns read data with fixed latency and readdatavalid.
- Sits between the interconnect and the RAM wrapper's s1 port.

Parameters:
ADDR_W, 9, word address width (512 words)
DATA_W, 32, data width; byteenable width = DATA_W/8
INIT_GRANT_LAST, 1, master treated as "last granted" after reset (1 means m0 wins first contention)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  DATA_W/8  master 0 byte lanes
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  master 0 stall; request not accepted this cycle
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m1_* (same set as m0_*)  -  -  master 1
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  DATA_W/8  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken; tied 1
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Request: reqN = mN_read | mN_write.
- Acceptance: mN is accepted in a cycle when reqN=1 and mN_waitrequest=0.
- Grant (combinational from registered last_grant):
  - only one requester: it wins;
  - both request: the master not equal to last_grant wins;
  - neither: no grant.
- mN_waitrequest = reqN & ~grantN. Combinational; never asserted when reqN=0.
- Memory drive (same cycle as grant): mem_* come from the granted master's address, byteenable, writedata and write.
  - mem_chipselect = grant0|grant1.
  - With no grant: mem_chipselect=0, mem_write=0, address/data don't-care (drive m0 values).
- last_grant register:
  - updates to the granted index on any grant;
  - holds when idle;
  - reset value INIT_GRANT_LAST.
- Read return pipeline: registers rd_pend (1b) and rd_id (1b).
  - On an accepted read: rd_pend<=1 and rd_id<=granted index; otherwise rd_pend<=0.
  - Next cycle: m{rd_id}_readdatavalid = rd_pend.
  - Fixed latency: readdatavalid exactly 1 cycle after acceptance.
- Read data: mN_readdata = mem_readdata for both masters, unqualified. Consumers qualify with readdatavalid.
- Read and write asserted together by one master (protocol violation): treated as a write; no readdatavalid.
- Back-to-back: a read can be accepted every cycle. A write immediately after a read is legal, because the RAM data for the read is already presented.
- Sustained contention: strict alternation m0,m1,m0,... Each master gets 50% throughput; no starvation.
- Reset (async assert, sync release): rd_pend=0, rd_id=0, last_grant=INIT_GRANT_LAST.
  - All readdatavalid deassert immediately.
  - A read in flight at reset assertion is dropped.
  - waitrequest and mem_* remain combinational from inputs.
- mem_clken fixed at 1. The RAM's reset_req is tied 0 at the system level.

Decomposition:
- Package nios_mem_arb_pkg:
  - ADDR_W/DATA_W defaults;
  - BE_W=DATA_W/8;
  - master-index constants M0=0, M1=1;
  - typedef for the master request bundle (address, byteenable, read, write, writedata).
- Sub-module nios_mem_arb_rr2: 2-way round-robin grant logic plus the last_grant register.
- Top holds the mux and the read-return pipeline.

Test Plan:
- After reset, m0 reads addr 0x005 alone (RAM preloaded 0x005=0xDEADBEEF) -> m0_waitrequest=0; m0_readdatavalid=1 on the next cycle with m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both write in the same cycle (m0: 0x010=0x11111111, m1: 0x011=0x22222222) -> cycle 1: m0 granted, m1_waitrequest=1; cycle 2: m1 granted; readbacks return both values.
- Both masters hold continuous reads for 8 cycles -> grants alternate m0,m1,...; 4 readdatavalids each, each with the correct id and data one cycle after acceptance.
- m1 writes 0x020=0xAABBCCDD with byteenable=4'b0101 over a word holding 0 -> readback 0x00BB00DD.
- m0 read accepted, then reset_n pulled low before the next edge -> m0_readdatavalid=0 immediately; after release, m0 wins first contention.
- m0 asserts read=1 and write=1 together (0x030=0x12345678) -> write performed; no readdatavalid; readback 0x12345678.
